// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full-depth storage, optional fall-through read, level and sticky error flags.
module sync_fifo #(
  parameter int Width       = 8,
  parameter int Depth       = 16,
  parameter int FallThrough = 0,
  parameter int AlmostFull  = 14,
  parameter int AlmostEmpty = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     write_req_i,
  input  logic [Width-1:0]         data_i,
  output logic                     write_valid_o,
  input  logic                     read_req_i,
  output logic                     read_valid_o,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] AF = (AW+1)'(AlmostFull);
  localparam logic [AW:0] AE = (AW+1)'(AlmostEmpty);
  logic [Width-1:0] mem_q [Depth];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] data_q, data_d;
  logic ovf_q, ovf_d, udf_q, udf_d, empty, full, wr_acc, rd_acc;
  // Pointers carry an extra wrap bit so full and empty are distinguishable with all Depth slots used.
  always_comb begin
    empty    = wr_ptr_q == rd_ptr_q;
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    wr_acc   = write_req_i && !full && !flush_i;
    rd_acc   = read_req_i && !empty && !flush_i;
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + (AW+1)'(rd_acc);
    data_d   = rd_acc ? mem_q[rd_ptr_q[AW-1:0]] : data_q;
    ovf_d    = !flush_i && (ovf_q || (write_req_i && full));
    udf_d    = !flush_i && (udf_q || (read_req_i && empty));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
  assign level_o        = wr_ptr_q - rd_ptr_q;
  assign write_valid_o  = !full;
  assign read_valid_o   = !empty;
  assign almost_full_o  = level_o >= AF;
  assign almost_empty_o = level_o <= AE;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign data_o         = FallThrough != 0 ? (empty ? '0 : mem_q[rd_ptr_q[AW-1:0]]) : data_q;
endmodule
